// File: rtl/shift_unit_seq_pkg.sv
// shift_unit_seq_pkg: shared types, constants and bit-reversal helper for the sequential shifter
package shift_unit_seq_pkg;
  localparam int LANES = 8;
  localparam int LANE_W = 8;
  localparam int DATA_W = LANES * LANE_W;
  typedef enum logic [1:0] {SLL = 2'd0, SRL = 2'd1, SRA = 2'd2} shift_op_t;
  typedef enum logic [1:0] {IDLE, BYTE, BIT, DONE} state_t;
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction
endpackage

// File: rtl/barrel_shifter_r.sv
// barrel_shifter_r: right shift of 2**N lanes of M bits by shamt_i whole lanes, optional sign fill
module barrel_shifter_r #(
  parameter int N = 3,
  parameter int M = 8
) (
  input  logic [(M<<N)-1:0] data_i,
  input  logic [N-1:0]      shamt_i,
  input  logic              arith_i,
  output logic [(M<<N)-1:0] data_o
);
  localparam int W = M << N;
  logic [W-1:0] stg [N+1];
  logic fill;
  assign fill = arith_i & data_i[W-1];
  assign stg[0] = data_i;
  for (genvar g = 0; g < N; g++) begin : g_stage
    assign stg[g+1] = shamt_i[g] ? {{(M << g){fill}}, stg[g][W-1:(M << g)]} : stg[g];
  end
  assign data_o = stg[N];
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shifter, one byte-granular step then one bit per cycle
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int DATA_SIZE = DATA_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [DATA_SIZE-1:0] operand_i,
  input  logic [5:0]           shamt_i,
  input  logic [1:0]           op_i,
  output logic [DATA_SIZE-1:0] result_o,
  output logic                 done_o
);
  state_t state_q, state_d;
  shift_op_t op_q;
  logic [DATA_SIZE-1:0] data_q, data_d, bs_out, shift1;
  logic [2:0] byte_q, rem_q, rem_d;
  logic accept, arith;
  assign accept = valid_i && ready_o;
  assign arith = op_q == SRA;
  assign shift1 = {arith & data_q[DATA_SIZE-1], data_q[DATA_SIZE-1:1]};
  barrel_shifter_r #(.N(3), .M(LANE_W)) u_bs (
    .data_i (data_q),
    .shamt_i(byte_q),
    .arith_i(arith),
    .data_o (bs_out)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? (accept ? BYTE : IDLE) :
              state_q == BYTE ? (rem_q != 3'd0 ? BIT : DONE) :
              state_q == BIT  ? (rem_q == 3'd1 ? DONE : BIT) : IDLE;
  end
  always_comb begin
    ready_o = state_q == IDLE && !rst_i;
  end
  // SLL runs through the right-shift path on bit-reversed data
  always_comb begin
    data_d = state_q == IDLE ? (accept ? (op_i == SLL ? bit_rev(operand_i) : operand_i) : data_q) :
             state_q == BYTE ? bs_out :
             state_q == BIT  ? shift1 : data_q;
    rem_d = state_q == IDLE ? (accept ? shamt_i[2:0] : rem_q) :
            state_q == BIT  ? rem_q - 3'd1 : rem_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      rem_q <= '0;
      byte_q <= '0;
      op_q <= SLL;
      result_o <= '0;
      done_o <= 1'b0;
    end else begin
      data_q <= data_d;
      rem_q <= rem_d;
      byte_q <= accept ? shamt_i[5:3] : byte_q;
      op_q <= accept ? shift_op_t'(op_i) : op_q;
      result_o <= state_d == DONE ? (op_q == SLL ? bit_rev(data_d) : data_d) : result_o;
      done_o <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: random and directed requests scored against an arithmetic shift model
module tb_shift_unit_seq;
  logic clk = 0, rst_i = 1, valid_i = 0;
  logic [63:0] operand_i = '0;
  logic [5:0] shamt_i = '0;
  logic [1:0] op_i = '0;
  logic ready_o, done_o;
  logic [63:0] result_o;
  typedef struct {
    logic [63:0] res;
    int lat;
    int acc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_pass = 0, prev_acc = 0, prev_lat = 0;
  shift_unit_seq #(.DATA_SIZE(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .operand_i(operand_i), .shamt_i(shamt_i), .op_i(op_i),
    .result_o(result_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at cycle %0d", nm, act, exp, cyc);
  endtask
  function automatic logic [63:0] model(input logic [63:0] a, input logic [5:0] s, input logic [1:0] o);
    logic [63:0] r;
    if (o == 2'd0) r = a << s;
    else if (o == 2'd2) r = $signed(a) >>> s;
    else r = a >> s;
    return r;
  endfunction
  task automatic issue(input logic [63:0] a, input logic [5:0] s, input logic [1:0] o,
                       input bit hold, input bit b2b);
    int n = 0;
    valid_i = 1;
    operand_i = a;
    shamt_i = s;
    op_i = o;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk("accept_timeout", 64'd0, 64'd1);
      valid_i = 0;
      return;
    end
    if (b2b) chk("b2b_accept_cycle", 64'(cyc + 1), 64'(prev_acc + prev_lat + 1));
    prev_acc = cyc + 1;
    prev_lat = 2 + int'(s[2:0]);
    q.push_back('{model(a, s, o), 2 + int'(s[2:0]), cyc + 1});
    @(negedge clk);
    operand_i = {$urandom, $urandom};
    shamt_i = 6'($urandom);
    op_i = 2'($urandom);
    if (!hold) valid_i = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(q.size()), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    logic [63:0] last = '0;
    bit was_rst;
    exp_t e;
    forever begin
      @(posedge clk);
      was_rst = rst_i;
      @(negedge clk);
      #1;
      if (was_rst) begin
        q.delete();
        last = '0;
        chk("reset_result", result_o, 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
      end else if (done_o) begin
        if (q.size() == 0) chk("spurious_done", 64'd1, 64'd0);
        else begin
          e = q.pop_front();
          chk("result", result_o, e.res);
          chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
          last = e.res;
        end
      end else chk("result_hold", result_o, last);
    end
  end
  initial begin
    bit h = 0, hn;
    repeat (3) begin
      @(negedge clk);
      chk("ready_in_reset", 64'(ready_o), 64'd0);
    end
    rst_i = 0;
    #1 chk("ready_after_reset", 64'(ready_o), 64'd1);
    @(negedge clk);
    issue(64'hF000_0000_0000_0000, 6'd4, 2'd1, 0, 0);
    issue(64'h8000_0000_0000_0000, 6'd63, 2'd2, 0, 0);
    issue(64'h8000_0000_0000_0000, 6'd63, 2'd1, 0, 0);
    issue(64'h1, 6'd8, 2'd0, 0, 0);
    issue(64'h1, 6'd63, 2'd0, 0, 0);
    for (int o = 0; o < 4; o++) issue(64'hDEAD_BEEF_0123_4567, 6'd0, 2'(o), 0, 0);
    issue(64'hDEAD_BEEF_0123_4567, 6'd12, 2'd3, 0, 0);
    drain();
    issue(64'h0123_4567_89AB_CDEF, 6'd5, 2'd2, 1, 0);
    issue(64'hFEDC_BA98_7654_3210, 6'd17, 2'd0, 0, 1);
    drain();
    for (int i = 0; i < 40; i++) begin
      hn = i < 39 && $urandom_range(0, 2) == 0;
      issue({$urandom, $urandom}, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)), hn, h);
      h = hn;
      if (!hn) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    issue(64'h8123_4567_89AB_CDEF, 6'd7, 2'd2, 0, 0);
    @(negedge clk);
    rst_i = 1;
    #1 chk("ready_in_reset", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst_i = 0;
    #1 chk("ready_after_abort", 64'(ready_o), 64'd1);
    @(negedge clk);
    issue(64'h8123_4567_89AB_CDEF, 6'd7, 2'd2, 0, 0);
    issue(64'h0000_FFFF_0000_FFFF, 6'd33, 2'd0, 0, 0);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/shift_unit_seq.md
SHIFT_UNIT_SEQ -- requirements
Module: shift_unit_seq

Interface
REQ-001 Parameter: DATA_SIZE, default 64, operand/result width; only 64 supported (8 lanes x 8 bits).
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid  input  1  request valid; operands sampled on accept.
REQ-005 ready  output  1  high only in IDLE while reset low; accept = valid && ready at a rising edge.
REQ-006 operand  input  DATA_SIZE  value to shift.
REQ-007 shamt  input  6  shift amount, 0..63.
REQ-008 op  input  2  shift_op_t: SLL, SRL, SRA; code 3 reserved.
REQ-009 result  output  DATA_SIZE  registered result, held until the next DONE entry.
REQ-010 done  output  1  registered one-cycle pulse marking a valid new result.

Function
REQ-011 FSM states: IDLE, BYTE, BIT, DONE.
REQ-012 IDLE: on accept, load data = operand (bit-reversed if SLL), byte_amt = shamt[5:3], rem = shamt[2:0], latch op; go to BYTE.
REQ-013 BYTE (exactly one cycle): data <= barrel-shift of data right by byte_amt*8 bits, sign fill for SRA, zero fill otherwise; go to BIT if rem != 0, else DONE.
REQ-014 BIT: each cycle data <= data shifted right 1 bit (sign fill for SRA, zero fill otherwise), rem <= rem - 1; go to DONE on the edge where rem == 1.
REQ-015 DONE entry edge: result <= data (bit-reversed if SLL), done <= 1; DONE lasts one cycle, then IDLE.
REQ-016 Latency: done high in cycle (accept edge + 2 + shamt[2:0]) edges, i.e. 2..9 cycles.
REQ-017 SLL implemented as reverse, right shift with zero fill, reverse; no separate left datapath.
REQ-018 op = 3 behaves exactly as SRL.
REQ-019 shamt = 0: result = operand, latency 2.
REQ-020 valid while not in IDLE ignored; no queuing; operand/shamt/op changes after accept have no effect.
REQ-021 ready is low during DONE; a request held valid is accepted on the first IDLE edge after DONE (min issue interval = latency + 1).
REQ-022 done low in every cycle except the single DONE cycle.

Reset
REQ-023 reset high at an edge: state <= IDLE, result <= 0, done <= 0, data/rem/byte_amt <= 0, from any state including mid-BYTE/BIT.
REQ-024 ready is 0 while reset is high; 1 from the first cycle after reset deasserts.
REQ-025 An operation aborted by reset never produces done or updates result.
REQ-026 reset has priority over accept in the same cycle.

Structure
REQ-027 shift_op_t (SLL=0, SRL=1, SRA=2) and the FSM state enum live in the shared core package; DATA_SIZE, lane count 8 and lane width 8 are package constants.
REQ-028 The byte step instantiates barrel_shifter_r with N=3, M=8 (shamt = byte_amt, arithmetic = (op == SRA)); all other logic is local.
REQ-029 Bit reversal is a combinational function in the same package.

Verification
REQ-030 SRL operand 0xF000_0000_0000_0000, shamt 4 -> result 0x0F00_0000_0000_0000, done 6 cycles after accept, single cycle.
REQ-031 SRA operand 0x8000_0000_0000_0000, shamt 63 -> result 0xFFFF_FFFF_FFFF_FFFF, done after 9 cycles; SRL same operand and shamt -> 0x1.
REQ-032 SLL operand 0x1, shamt 8 -> 0x100, done after 2 cycles; SLL 0x1, shamt 63 -> 0x8000_0000_0000_0000, done after 9 cycles.
REQ-033 shamt 0 with each op on 0xDEAD_BEEF_0123_4567 -> result unchanged, latency 2; op = 3, shamt 12 -> same as SRL.
REQ-034 valid held high for two requests -> second accepted only on the edge after DONE; result holds the first value until the second DONE.
REQ-035 reset asserted in BIT state (SRA shamt 7) -> no done, result 0, ready 1 in the cycle after reset deasserts; next request completes correctly.
